divider_rr_scheduler: RTL and testbench
=======================================

Name: divider_rr_scheduler

Overview:
Shares one sequential non-restoring divider (start/done handshake, multi-cycle latency) between NUM_REQ requesters. Arbitrates round-robin and launches one division at a time. Returns quotient and remainder tagged with the requester ID. Divide-by-zero requests are resolved locally, and a watchdog recovers from a divider that never asserts done.

Parameters:
NUM_REQ, 4, number of requesters.
WIDTH, 4, dividend/divisor/quotient/remainder width; matches divider datapath width.
ID_W, 2, width of requester ID; NUM_REQ <= 2**ID_W.
TIMEOUT, 31, max cycles spent in WAIT before abort.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid; held until accepted
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_dividend  in  NUM_REQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor  in  NUM_REQ*WIDTH  packed divisors, same packing
div_start  out  1  one-cycle start pulse to divider
div_dividend  out  WIDTH  operand to divider, stable from ISSUE through WAIT
div_divisor  out  WIDTH  operand to divider, stable from ISSUE through WAIT
div_done  in  1  divider completion, sampled only in WAIT
div_quotient  in  WIDTH  divider quotient, valid with div_done
div_remainder  in  WIDTH  divider remainder, valid with div_done
div_abort  out  1  one-cycle pulse on watchdog expiry
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index of response
rsp_quotient  out  WIDTH  result quotient
rsp_remainder  out  WIDTH  result remainder
rsp_dz  out  1  divide-by-zero flag
rsp_timeout  out  1  watchdog flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset state:
  - State IDLE, rr_ptr=0, watchdog=0.
  - All outputs 0: req_ready, div_start, div_abort, rsp_*, busy, div_dividend, div_divisor.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only; the handshake is the accept.
  - On accept, register operands and ID.
  - If divisor==0: go to RESP with rsp_quotient={WIDTH{1}}, rsp_remainder=dividend, rsp_dz=1.
  - Otherwise go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - div_start=1 for exactly this cycle; watchdog cleared; next state WAIT.
  - div_done is ignored in this state.
- WAIT:
  - watchdog increments each cycle.
  - div_done=1: register div_quotient/div_remainder into rsp_*, dz=0, timeout=0, go to RESP.
  - Else if watchdog==TIMEOUT-1: div_abort=1 for this cycle; rsp_quotient=0, rsp_remainder=0, rsp_timeout=1; go to RESP.
  - If div_done and expiry coincide, done wins and there is no abort.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready=1.
  - On handshake: rr_ptr=(rsp_id+1) mod NUM_REQ; go to IDLE.
  - The next accept occurs no earlier than the following cycle.
- req_ready is 0 in every state except IDLE. Only one division is in flight at any time.
- Latency, accept to rsp_valid:
  - Normal: divider latency + 2 cycles.
  - Divide-by-zero: 1 cycle.
  - Timeout: TIMEOUT + 2 cycles.
- Requesters not granted keep req_valid asserted. Starvation bound: NUM_REQ-1 intervening grants.
- Dropping req_valid while not granted is allowed and simply removes that requester from arbitration.
- Reset mid-operation abandons the job: no response, no div_abort. The divider shares rst and is reset alongside.
- Unsigned arithmetic only. No width extension: operands pass to the divider unchanged.

Test Plan:
1. req_valid=0001, dividend 13, divisor 3; divider model asserts done after 20 cycles with q=4, r=1. -> req_ready=0001 at T, div_start only at T+1, rsp_valid at T+23 with id=0, q=4, r=1, dz=0, timeout=0.
2. req_valid=1111 held, all with divisor 2, rsp_ready=1. -> grants in order 0,1,2,3; re-request 0 and 2 after that -> next grants 0 then 2.
3. Requester 1: dividend 9, divisor 0. -> rsp_valid at T+1 with id=1, q=4'hF, r=9, dz=1; div_start never pulses.
4. Divisor 5, div_done never asserted, TIMEOUT=31. -> div_abort single pulse on the 31st WAIT cycle; rsp timeout=1, q=0, r=0; the next request is then served normally.
5. rsp_ready held low 5 cycles with other requests pending. -> rsp_* stable, req_ready=0 throughout; accept occurs the cycle after the RESP handshake.
6. Assert rst for one cycle during WAIT. -> next cycle all outputs 0, no response for the aborted job; with req_valid=1010 the next grant goes to requester 1 (rr_ptr reset to 0).

Source files
------------

// File: rtl/divider_rr_scheduler.sv
// Round-robin front end that shares one multi-cycle divider between NUM_REQ requesters.
// Zero divisors are answered locally, and a watchdog aborts a divider that never completes.
module divider_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic                     div_done,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    output logic                     div_abort,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_dz,
    output logic                     rsp_timeout,
    output logic                     busy
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dz_q, dz_d;
    logic              to_q, to_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_dvd;
    logic [WIDTH-1:0]  grant_dvs;

    // Scan starts at rr_ptr so the last-served requester goes to the back of the line.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        grant_dvd = req_dividend[int'(grant_idx)*WIDTH +: WIDTH];
        grant_dvs = req_divisor[int'(grant_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wd_d       = wd_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        to_d       = to_q;
        req_ready  = '0;
        div_start  = 1'b0;
        div_abort  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    id_d       = grant_idx;
                    dividend_d = grant_dvd;
                    divisor_d  = grant_dvs;
                    if (grant_dvs == '0) begin
                        quo_d   = '1;
                        rem_d   = grant_dvd;
                        dz_d    = 1'b1;
                        to_d    = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (div_done) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    dz_d    = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    div_abort = 1'b1;
                    quo_d     = '0;
                    rem_d     = '0;
                    dz_d      = 1'b0;
                    to_d      = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            wd_q       <= '0;
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wd_q       <= wd_d;
            id_q       <= id_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            to_q       <= to_d;
        end
    end

    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_dz        = dz_q;
    assign rsp_timeout   = to_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_divider_rr_scheduler.sv
// Directed bench for divider_rr_scheduler with a behavioural divider of programmable latency.
module tb_divider_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_dividend;
    logic [15:0] req_divisor;
    logic        div_start;
    logic [3:0]  div_dividend;
    logic [3:0]  div_divisor;
    logic        div_done;
    logic [3:0]  div_quotient;
    logic [3:0]  div_remainder;
    logic        div_abort;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_quotient;
    logic [3:0]  rsp_remainder;
    logic        rsp_dz;
    logic        rsp_timeout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    divider_rr_scheduler #(.NUM_REQ(4), .WIDTH(4), .ID_W(2), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_abort(div_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dz(rsp_dz), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: done is high during WAIT cycle number div_lat (0 = never completes).
    int         div_lat   = 1;
    int         cnt       = 0;
    int         start_cnt = 0;
    int         abort_cnt = 0;
    int         abort_at  = 0;
    logic [3:0] m_q, m_r;

    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    always @(posedge clk) begin
        if (rst) begin
            cnt      <= 0;
            div_done <= 1'b0;
        end else begin
            if (div_start) begin
                cnt      <= 1;
                div_done <= (div_lat == 1);
                m_q      <= (div_divisor != 0) ? div_dividend / div_divisor : 4'd0;
                m_r      <= (div_divisor != 0) ? div_dividend % div_divisor : 4'd0;
            end else if (div_done || div_abort) begin
                cnt      <= 0;
                div_done <= 1'b0;
            end else if (cnt != 0) begin
                cnt      <= cnt + 1;
                div_done <= (div_lat != 0) && (cnt + 1 == div_lat);
            end
            if (div_start) start_cnt <= start_cnt + 1;
            if (div_abort) begin
                abort_cnt <= abort_cnt + 1;
                abort_at  <= cnt;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [3:0] dvd, input logic [3:0] dvs);
        req_dividend[i*4 +: 4] = dvd;
        req_divisor[i*4 +: 4]  = dvs;
    endtask

    // Called at a negedge while IDLE with req_valid/operands already driven.
    task automatic job(input string tag, input logic [3:0] exp_grant, input int exp_lat,
                       input logic [1:0] exp_id, input logic [3:0] exp_q, input logic [3:0] exp_r,
                       input logic exp_dz, input logic exp_to);
        int lat;
        #1;
        check({tag, "_grant"}, req_ready, exp_grant);
        tick();
        req_valid = req_valid & ~exp_grant;
        check({tag, "_start"}, div_start, !exp_dz);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_id"}, rsp_id, exp_id);
        check({tag, "_q"}, rsp_quotient, exp_q);
        check({tag, "_r"}, rsp_remainder, exp_r);
        check({tag, "_dz"}, rsp_dz, exp_dz);
        check({tag, "_to"}, rsp_timeout, exp_to);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, rsp_valid, div_start, div_abort, rsp_dz, rsp_timeout, req_ready,
                div_dividend, div_divisor, rsp_id, rsp_quotient, rsp_remainder};
    endfunction

    logic [3:0] t2_grant [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    logic [1:0] t2_id    [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [3:0] t2_q     [6] = '{4'd4, 4'd4, 4'd5, 4'd5, 4'd4, 4'd5};
    logic [3:0] t2_r     [6] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0};

    initial begin
        int s0, a0, viol, seen;
        logic [31:0] snap;

        rst = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_outs", all_outs(), 0);
        tick();

        // Round-robin over all four, then 0 and 2 re-request.
        div_lat = 1;
        set_op(0, 4'd8, 4'd2); set_op(1, 4'd9, 4'd2); set_op(2, 4'd10, 4'd2); set_op(3, 4'd11, 4'd2);
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req_valid = 4'b0101;
            job($sformatf("t2_%0d", i), t2_grant[i], 3, t2_id[i], t2_q[i], t2_r[i], 1'b0, 1'b0);
        end

        // 13/3 with a 21-cycle WAIT before done.
        div_lat = 21;
        s0 = start_cnt;
        set_op(0, 4'd13, 4'd3);
        req_valid = 4'b0001;
        job("t1", 4'b0001, 23, 2'd0, 4'd4, 4'd1, 1'b0, 1'b0);
        check("t1_starts", start_cnt - s0, 1);

        // Divide by zero on requester 1.
        s0 = start_cnt;
        set_op(1, 4'd9, 4'd0);
        req_valid = 4'b0010;
        job("t3", 4'b0010, 1, 2'd1, 4'hF, 4'd9, 1'b1, 1'b0);
        check("t3_starts", start_cnt - s0, 0);

        // Divider never completes: watchdog abort, then a normal job.
        div_lat = 0;
        a0 = abort_cnt;
        set_op(2, 4'd7, 4'd5);
        req_valid = 4'b0100;
        job("t4", 4'b0100, 33, 2'd2, 4'd0, 4'd0, 1'b0, 1'b1);
        check("t4_aborts", abort_cnt - a0, 1);
        check("t4_abort_cycle", abort_at, 31);
        div_lat = 3;
        set_op(3, 4'd14, 4'd4);
        req_valid = 4'b1000;
        job("t4b", 4'b1000, 5, 2'd3, 4'd3, 4'd2, 1'b0, 1'b0);

        // Back-pressure on the response with requester 1 pending.
        div_lat = 1;
        set_op(0, 4'd6, 4'd3); set_op(1, 4'd11, 4'd3);
        req_valid = 4'b0011;
        #1;
        check("t5_grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        seen = 0;
        while (!rsp_valid && seen < 50) begin
            tick();
            seen++;
        end
        check("t5_rsp_seen", rsp_valid, 1);
        snap = {rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_timeout};
        check("t5_data", snap, {2'd0, 4'd2, 4'd0, 1'b0, 1'b0});
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!rsp_valid || req_ready != 0 ||
                {rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_timeout} != snap) viol++;
            tick();
        end
        check("t5_stable", viol, 0);
        rsp_ready = 1'b1;
        #1;
        check("t5_no_accept_in_resp", req_ready, 4'b0000);
        tick();
        rsp_ready = 1'b0;
        job("t5b", 4'b0010, 3, 2'd1, 4'd3, 4'd2, 1'b0, 1'b0);

        // Reset while waiting on the divider.
        div_lat = 0;
        a0 = abort_cnt;
        set_op(2, 4'd5, 4'd1);
        req_valid = 4'b0100;
        #1;
        check("t6_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        tick(); tick();
        check("t6_busy_in_wait", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_reset_outs", all_outs(), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", seen, 0);
        check("t6_no_abort", abort_cnt - a0, 0);
        div_lat = 2;
        set_op(1, 4'd4, 4'd2); set_op(3, 4'd9, 4'd2);
        req_valid = 4'b1010;
        job("t6b", 4'b0010, 4, 2'd1, 4'd2, 4'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
